// File: rtl/mmio_spin_unit.sv
// mmio_spin_unit: memory-mapped roulette-spin peripheral sitting beside the
// data RAM on the processor dmem bus.
//
// Register window (word offsets from BASE_ADDR, address bits [11:0]):
//   +0 CTRL   W   bit0 start, bit1 clear done, bit2 irq enable
//   +1 STATUS R   {29'b0, ie, done, busy}
//   +2 RESULT R   zero-extended target pocket
//   +3 SEED   W   loads LFSR (a zero write is ignored)
//   +4 TICKS  RW  16-bit spin duration in cycles, reset 200
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous active-low reset
//   wren          processor dmem write enable
//   address_dmem  processor dmem address (bits [11:0] decoded)
//   data          processor write data
//   q_ram         read data from RAM
//   ram_wren      RAM write enable, suppressed inside the window
//   q_dmem        read data to processor (one-cycle synchronous)
//   pocket        currently displayed pocket
//   busy          spin in progress
//   done          result valid
//   irq           done & ie, registered (only with SPIN_IRQ_EN defined,
//                 otherwise tied low)
//
// Optional feature macro: SPIN_IRQ_EN.
module mmio_spin_unit #(
  parameter int unsigned NUM_POCKETS = 37,
  parameter logic [11:0] BASE_ADDR   = 12'hF00,
  parameter logic [31:0] LFSR_RESET  = 32'hACE1_2468
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wren,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic [31:0] q_ram,
  output logic        ram_wren,
  output logic [31:0] q_dmem,
  output logic [5:0]  pocket,
  output logic        busy,
  output logic        done,
  output logic        irq
);

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [5:0]  NP        = 6'(NUM_POCKETS);
  localparam logic [5:0]  NP_LAST   = 6'(NUM_POCKETS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SPIN, ST_SETTLE, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  pocket_q, pocket_d;
  logic [5:0]  target_q, target_d;
  logic [15:0] tick_q, tick_d;
  logic [7:0]  pre_q, pre_d;
  logic [7:0]  step_q, step_d;
  logic        ie_q, ie_d;
  logic [15:0] ticks_q, ticks_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic        sel_q, sel_d;
  logic [31:0] rdata_q, rdata_d;

  logic [11:0] off;
  logic        in_window;
  logic        wr_ctrl, wr_seed, wr_ticks;
  logic        start, clr;
  logic [31:0] lfsr_step;
  logic [21:0] prod;
  logic [5:0]  pocket_inc;
  logic [7:0]  pre_sat;
  logic        step_adv;

  // Upper address bits are outside the decoded dmem space.
  logic addr_hi_unused;
  assign addr_hi_unused = ^address_dmem[31:12];

  // Addresses below BASE_ADDR wrap to a large offset and fall out of range.
  assign off       = address_dmem[11:0] - BASE_ADDR;
  assign in_window = (off < 12'd5);
  assign ram_wren  = wren & ~in_window;

  assign wr_ctrl  = wren & in_window & (off[2:0] == 3'd0);
  assign wr_seed  = wren & in_window & (off[2:0] == 3'd3);
  assign wr_ticks = wren & in_window & (off[2:0] == 3'd4);
  assign start    = wr_ctrl & data[0];
  assign clr      = wr_ctrl & data[1];

  assign lfsr_step = lfsr_q[0] ? ({1'b0, lfsr_q[31:1]} ^ LFSR_TAPS)
                               : {1'b0, lfsr_q[31:1]};

  // Top bits of a 16 x 6 product: a uniform pick in 0..NUM_POCKETS-1.
  assign prod = {6'b0, lfsr_q[15:0]} * {16'b0, NP};

  assign pocket_inc = (pocket_q == NP_LAST) ? '0 : pocket_q + 6'd1;
  assign pre_sat    = (pre_q == 8'hFF) ? 8'hFF : pre_q + 8'd1;
  assign step_adv   = (step_q == 8'd1);

  always_comb begin
    state_d  = state_q;
    pocket_d = pocket_q;
    target_d = target_q;
    tick_d   = tick_q;
    pre_d    = pre_q;
    step_d   = step_q;
    ie_d     = ie_q;
    ticks_d  = ticks_q;
    lfsr_d   = lfsr_step;
    sel_d    = in_window;
    rdata_d  = '0;

    if (wr_seed && (data != '0)) lfsr_d = data;
    if (wr_ctrl) ie_d = data[2];
    if (wr_ticks) ticks_d = data[15:0];

    unique case (off[2:0])
      3'd1:    rdata_d = {29'b0, ie_q, done, busy};
      3'd2:    rdata_d = {26'b0, target_q};
      3'd4:    rdata_d = {16'b0, ticks_q};
      default: rdata_d = '0;
    endcase

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_SPIN;
          target_d = prod[21:16];
          tick_d   = ticks_q;
          pre_d    = 8'd1;
          step_d   = 8'd1;
        end else if ((state_q == ST_DONE) && clr) begin
          state_d = ST_IDLE;
        end
      end
      ST_SPIN: begin
        // A zero or one tick count both leave after this single cycle.
        tick_d = (tick_q != '0) ? tick_q - 16'd1 : '0;
        if (tick_q <= 16'd1) state_d = ST_SETTLE;
        if (step_adv) begin
          pocket_d = pocket_inc;
          pre_d    = pre_sat;
          step_d   = pre_sat;
        end else begin
          step_d = step_q - 8'd1;
        end
      end
      ST_SETTLE: begin
        if (step_adv) begin
          pocket_d = pocket_inc;
          step_d   = pre_q;
          if (pocket_inc == target_q) state_d = ST_DONE;
        end else begin
          step_d = step_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pocket_q <= '0;
      target_q <= '0;
      tick_q   <= '0;
      pre_q    <= 8'd1;
      step_q   <= 8'd1;
      ie_q     <= 1'b0;
      ticks_q  <= 16'd200;
      lfsr_q   <= LFSR_RESET;
      sel_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      pocket_q <= pocket_d;
      target_q <= target_d;
      tick_q   <= tick_d;
      pre_q    <= pre_d;
      step_q   <= step_d;
      ie_q     <= ie_d;
      ticks_q  <= ticks_d;
      lfsr_q   <= lfsr_d;
      sel_q    <= sel_d;
      rdata_q  <= rdata_d;
    end
  end

  assign busy   = (state_q == ST_SPIN) || (state_q == ST_SETTLE);
  assign done   = (state_q == ST_DONE);
  assign pocket = pocket_q;
  assign q_dmem = sel_q ? rdata_q : q_ram;

`ifdef SPIN_IRQ_EN
  logic irq_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) irq_q <= 1'b0;
    else        irq_q <= done & ie_q;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_spin_unit.sv
// Directed bench for mmio_spin_unit with a small registered RAM model on the
// dmem side. Expected values are hand-derived pocket/cycle counts.
module tb_mmio_spin_unit;

  logic        clock;
  logic        reset;
  logic        wren;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic [31:0] q_ram;
  logic        ram_wren;
  logic [31:0] q_dmem;
  logic [5:0]  pocket;
  logic        busy;
  logic        done;
  logic        irq;

  int checks = 0;
  int errors = 0;

`ifdef SPIN_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  mmio_spin_unit #(
    .NUM_POCKETS(37),
    .BASE_ADDR  (12'hF00),
    .LFSR_RESET (32'hACE1_2468)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .wren        (wren),
    .address_dmem(address_dmem),
    .data        (data),
    .q_ram       (q_ram),
    .ram_wren    (ram_wren),
    .q_dmem      (q_dmem),
    .pocket      (pocket),
    .busy        (busy),
    .done        (done),
    .irq         (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered-read RAM model
  logic [31:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = '0;
  always @(posedge clock or negedge reset) begin
    if (!reset) q_ram <= '0;
    else begin
      if (ram_wren) mem[address_dmem[7:0]] <= data;
      q_ram <= mem[address_dmem[7:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d, output logic rw);
    @(negedge clock);
    address_dmem = {20'b0, a};
    data = d;
    wren = 1'b1;
    #1 rw = ram_wren;
    @(posedge clock); #1;
    wren = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] v);
    @(negedge clock);
    address_dmem = {20'b0, a};
    wren = 1'b0;
    @(posedge clock); #1;
    v = q_dmem;
  endtask

  task automatic run_until_done(input int n_in, input int limit, output int n_out);
    int n;
    n = n_in;
    while (!done && n < limit) begin
      tick();
      n++;
    end
    n_out = n;
  endtask

  logic [31:0] v;
  logic        rw;
  int          n;

  initial begin
    reset = 1'b0;
    wren = 1'b0;
    address_dmem = '0;
    data = '0;

    // Reset state and combinational write gating
    #2;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_pocket", {26'b0, pocket}, 0);
    check("rst_irq", {31'b0, irq}, 0);
    check("rst_qdmem", q_dmem, 0);
    address_dmem = 32'h010; wren = 1'b1; #1;
    check("rst_ramwren_out", {31'b0, ram_wren}, 1);
    address_dmem = 32'hF00; #1;
    check("rst_ramwren_in", {31'b0, ram_wren}, 0);
    wren = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;

    bus_read(12'hF01, v); check("status_rst", v, 0);
    bus_read(12'hF04, v); check("ticks_rst", v, 200);

    // Spin 1: TICKS=10, seed 1 -> target 0
    bus_write(12'hF04, 32'd10, rw);
    bus_write(12'hF03, 32'd1, rw);
    bus_write(12'hF00, 32'd1, rw);
    check("s1_busy", {31'b0, busy}, 1);
    check("s1_done0", {31'b0, done}, 0);
    n = 0;
    while (!done && n < 400) begin
      tick();
      n++;
      case (n)
        1:  check("s1_p1", {26'b0, pocket}, 1);
        2:  check("s1_p2", {26'b0, pocket}, 1);
        3:  check("s1_p3", {26'b0, pocket}, 2);
        5:  check("s1_p5", {26'b0, pocket}, 2);
        6:  check("s1_p6", {26'b0, pocket}, 3);
        10: check("s1_p10", {26'b0, pocket}, 4);
        14: check("s1_p14", {26'b0, pocket}, 4);
        15: check("s1_p15", {26'b0, pocket}, 5);
        default: ;
      endcase
    end
    check("s1_cycles", n, 175);
    check("s1_pocket", {26'b0, pocket}, 0);
    check("s1_busy_end", {31'b0, busy}, 0);
    check("s1_irq", {31'b0, irq}, 0);
    bus_read(12'hF02, v); check("s1_result", v, 0);
    bus_read(12'hF01, v); check("s1_status", v, 2);

    // Window gating and RAM passthrough
    bus_write(12'hF02, 32'd5, rw); check("ro_ramwren", {31'b0, rw}, 0);
    bus_read(12'hF02, v); check("ro_result", v, 0);
    bus_write(12'hF05, 32'hABCD, rw); check("f05_ramwren", {31'b0, rw}, 1);
    bus_write(12'h010, 32'h1234_5678, rw); check("ram_ramwren", {31'b0, rw}, 1);
    bus_read(12'h010, v); check("ram_read", v, 32'h1234_5678);
    bus_read(12'hF05, v); check("ram_read_f05", v, 32'hABCD);

    // Spin 2: start+clear from DONE, start while busy ignored, target 18
    bus_write(12'hF03, 32'h0000_8000, rw);
    bus_write(12'hF00, 32'd3, rw);
    check("s2_done0", {31'b0, done}, 0);
    check("s2_busy", {31'b0, busy}, 1);
    bus_write(12'hF00, 32'd1, rw);
    run_until_done(1, 400, n);
    check("s2_cycles", n, 80);
    check("s2_pocket", {26'b0, pocket}, 18);
    bus_read(12'hF02, v); check("s2_result", v, 18);

    // Spin 3: irq enable, then clear
    bus_write(12'hF03, 32'h0000_8000, rw);
    bus_write(12'hF00, 32'd5, rw);
    run_until_done(0, 400, n);
    check("s3_cycles", n, 175);
    check("s3_irq_at_done", {31'b0, irq}, 0);
    tick();
    check("s3_irq_rise", {31'b0, irq}, {31'b0, IRQ_ON});
    bus_read(12'hF01, v); check("s3_status", v, 6);
    bus_write(12'hF00, 32'd2, rw);
    check("s3_done_clr", {31'b0, done}, 0);
    check("s3_pocket_held", {26'b0, pocket}, 18);
    check("s3_irq_hold", {31'b0, irq}, {31'b0, IRQ_ON});
    tick();
    check("s3_irq_fall", {31'b0, irq}, 0);

    // Spin 4: reset mid-SETTLE
    bus_write(12'hF00, 32'd1, rw);
    repeat (20) tick();
    check("s4_busy_pre", {31'b0, busy}, 1);
    #2 reset = 1'b0;
    #1;
    check("s4_busy", {31'b0, busy}, 0);
    check("s4_pocket", {26'b0, pocket}, 0);
    check("s4_qdmem", q_dmem, 0);
    check("s4_done", {31'b0, done}, 0);
    @(negedge clock) reset = 1'b1;
    bus_read(12'hF04, v); check("s4_ticks", v, 200);

    // Spin 5: TICKS=0, single SPIN cycle, target 18
    bus_write(12'hF04, 32'd0, rw);
    bus_write(12'hF03, 32'h0000_8000, rw);
    bus_write(12'hF00, 32'd1, rw);
    check("s5_busy", {31'b0, busy}, 1);
    tick();
    check("s5_p1", {26'b0, pocket}, 1);
    run_until_done(1, 400, n);
    check("s5_cycles", n, 35);
    check("s5_pocket", {26'b0, pocket}, 18);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
